// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data bits LSB-first, 1 stop; payload optionally re-inverted.
// Optional build macro UART_RX_MAJORITY_EN: sample points take a 3-sample majority of rx_s.
module uart_rx #(
  parameter int BAUD_RATE      = 115_200,
  parameter int CLOCK_SPEED    = 50_000_000,
  parameter bit INVERT_PAYLOAD = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       framing_err,
  output logic       busy
);
  localparam int BAUD_WIDTH = CLOCK_SPEED / BAUD_RATE;
  localparam int HALF_WIDTH = BAUD_WIDTH / 2;
  localparam int CW         = $clog2(BAUD_WIDTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_WIDTH - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          framing_err_q, framing_err_d;
  logic          sync1_q, sync1_d;
  logic          rx_s_q, rx_s_d;
  logic          samp;

`ifdef UART_RX_MAJORITY_EN
  // Two older rx_s values; together with rx_s they form the voting window.
  logic [1:0] hist_q, hist_d;
  assign hist_d = {hist_q[0], rx_s_q};
  assign samp   = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
  always_ff @(posedge clk) begin
    if (!rst) hist_q <= 2'b11;
    else      hist_q <= hist_d;
  end
`else
  assign samp = rx_s_q;
`endif

  always_comb begin
    sync1_d       = rx;
    rx_s_d        = sync1_q;
    state_d       = state_q;
    cnt_d         = '0;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    data_d        = data_q;
    rx_valid_d    = 1'b0;
    framing_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          bit_idx_d = 3'd0;
          state_d   = samp ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BAUD_LAST) begin
          shreg_d[bit_idx_q] = samp;
          bit_idx_d          = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch the next start edge.
        if (cnt_q == BAUD_LAST) begin
          if (samp) begin
            data_d     = INVERT_PAYLOAD ? ~shreg_q : shreg_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            framing_err_d = 1'b1;
            state_d       = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q       <= 1'b1;
      rx_s_q        <= 1'b1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      shreg_q       <= 8'h00;
      data_q        <= 8'h00;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      rx_s_q        <= rx_s_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      data_q        <= data_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
    end
  end

  assign data        = data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign busy        = (state_q != IDLE);
endmodule
